// File: rtl/morse_pkg.sv
// morse_pkg -- shared constants and FSM state type for the Morse receive path.
// Revision: 1.0
`default_nettype none

package morse_pkg;

  localparam int         UNIT_CHAR_GAP = 2;
  localparam int         UNIT_WORD_GAP = 6;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_GAP  = 2'd2,
    ST_WORD = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/morse2ascii_lut.sv
// morse2ascii_lut -- element pattern (first element in bit 0, dash = 1) to ASCII.
// Revision: 1.0
`default_nettype none

module morse2ascii_lut
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [5:0] code,
  output logic [7:0] ascii,
  output logic       hit
);

  always_comb begin
    ascii = ASCII_UNKNOWN;
    hit   = 1'b1;
    case ({len, code})
      {3'd1, 6'b000000}: ascii = "E";
      {3'd1, 6'b000001}: ascii = "T";
      {3'd2, 6'b000010}: ascii = "A";
      {3'd2, 6'b000000}: ascii = "I";
      {3'd2, 6'b000011}: ascii = "M";
      {3'd2, 6'b000001}: ascii = "N";
      {3'd3, 6'b000001}: ascii = "D";
      {3'd3, 6'b000011}: ascii = "G";
      {3'd3, 6'b000101}: ascii = "K";
      {3'd3, 6'b000111}: ascii = "O";
      {3'd3, 6'b000010}: ascii = "R";
      {3'd3, 6'b000000}: ascii = "S";
      {3'd3, 6'b000100}: ascii = "U";
      {3'd3, 6'b000110}: ascii = "W";
      {3'd4, 6'b000001}: ascii = "B";
      {3'd4, 6'b000101}: ascii = "C";
      {3'd4, 6'b000100}: ascii = "F";
      {3'd4, 6'b000000}: ascii = "H";
      {3'd4, 6'b001110}: ascii = "J";
      {3'd4, 6'b000010}: ascii = "L";
      {3'd4, 6'b000110}: ascii = "P";
      {3'd4, 6'b001011}: ascii = "Q";
      {3'd4, 6'b001000}: ascii = "V";
      {3'd4, 6'b001001}: ascii = "X";
      {3'd4, 6'b001101}: ascii = "Y";
      {3'd4, 6'b000011}: ascii = "Z";
      {3'd5, 6'b011111}: ascii = "0";
      {3'd5, 6'b011110}: ascii = "1";
      {3'd5, 6'b011100}: ascii = "2";
      {3'd5, 6'b011000}: ascii = "3";
      {3'd5, 6'b010000}: ascii = "4";
      {3'd5, 6'b000000}: ascii = "5";
      {3'd5, 6'b000001}: ascii = "6";
      {3'd5, 6'b000011}: ascii = "7";
      {3'd5, 6'b000111}: ascii = "8";
      {3'd5, 6'b001111}: ascii = "9";
      default:           hit   = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/morse2ascii.sv
// morse2ascii -- decodes an on-off-keyed Morse line into ASCII bytes on a valid/ready port.
// Revision: 1.0
`default_nettype none

module morse2ascii
  import morse_pkg::*;
#(
  parameter int PRESCALER = 100000,
  parameter int MAX_ELEM  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       morse_in,
  output logic [7:0] ascii_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun
);

  localparam int            CW       = $clog2(PRESCALER);
  localparam logic [CW-1:0] CYC_HALF = CW'(PRESCALER / 2);
  localparam logic [CW-1:0] CYC_LAST = CW'(PRESCALER - 1);
  localparam logic [2:0]    LEN_MAX  = 3'(MAX_ELEM);
  localparam logic [2:0]    U_CHAR   = 3'(UNIT_CHAR_GAP);
  localparam logic [2:0]    U_WORD   = 3'(UNIT_WORD_GAP);

  logic          sync1_q, s_q;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    units_q, units_d;
  state_e        state_q, state_d, prev_q, prev_d;
  logic [5:0]    code_q, code_d;
  logic [2:0]    len_q, len_d;
  logic          err_q, err_d;
  logic [7:0]    ascii_q, ascii_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  logic          s_edge, s_rise, s_fall;
  logic          emit;
  logic [7:0]    emit_byte;
  logic [7:0]    lut_ascii;
  logic          lut_hit;

  // Edges are taken where s_q is about to change, so the timer reloads on the same clock as s_q.
  assign s_edge = sync1_q ^ s_q;
  assign s_rise = s_edge & sync1_q;
  assign s_fall = s_edge & ~sync1_q;

  morse2ascii_lut u_lut (
    .len   (len_q),
    .code  (code_q),
    .ascii (lut_ascii),
    .hit   (lut_hit)
  );

  always_comb begin
    cyc_d   = cyc_q;
    units_d = units_q;
    if (s_edge) begin
      cyc_d   = CYC_HALF;
      units_d = 3'd0;
    end else if (cyc_q == CYC_LAST) begin
      cyc_d = '0;
      if (units_q != 3'd7) units_d = units_q + 3'd1;
    end else begin
      cyc_d = cyc_q + CW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    code_d    = code_q;
    len_d     = len_q;
    err_d     = err_q;
    emit      = 1'b0;
    emit_byte = ASCII_SPACE;
    case (state_q)
      ST_IDLE: begin
        if (s_rise) begin
          prev_d  = ST_IDLE;
          state_d = ST_MARK;
        end
      end
      ST_MARK: begin
        if (s_fall) begin
          if (units_q == 3'd0) begin
            state_d = prev_q;
          end else begin
            state_d = ST_GAP;
            if (len_q == LEN_MAX) begin
              err_d = 1'b1;
            end else begin
              code_d = code_q | (6'(units_q >= 3'd2) << len_q);
              len_d  = len_q + 3'd1;
            end
          end
        end
      end
      ST_GAP: begin
        if (units_q >= U_CHAR) begin
          emit      = 1'b1;
          emit_byte = (err_q || !lut_hit) ? ASCII_UNKNOWN : lut_ascii;
          code_d    = '0;
          len_d     = '0;
          err_d     = 1'b0;
          prev_d    = ST_WORD;
          state_d   = s_rise ? ST_MARK : ST_WORD;
        end else if (s_rise) begin
          prev_d  = ST_GAP;
          state_d = ST_MARK;
        end
      end
      ST_WORD: begin
        if (units_q >= U_WORD) begin
          emit    = 1'b1;
          prev_d  = ST_IDLE;
          state_d = s_rise ? ST_MARK : ST_IDLE;
        end else if (s_rise) begin
          prev_d  = ST_WORD;
          state_d = ST_MARK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ascii_d = ascii_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (emit) begin
      if (!valid_q || out_ready) begin
        ascii_d = emit_byte;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Synchronizer resets high so a line already keyed at release gives no rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      cyc_q   <= '0;
      units_q <= '0;
      state_q <= ST_IDLE;
      prev_q  <= ST_IDLE;
      code_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      ascii_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= morse_in;
      s_q     <= sync1_q;
      cyc_q   <= cyc_d;
      units_q <= units_d;
      state_q <= state_d;
      prev_q  <= prev_d;
      code_q  <= code_d;
      len_q   <= len_d;
      err_q   <= err_d;
      ascii_q <= ascii_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ascii_out = ascii_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_morse2ascii.sv
// tb_morse2ascii -- directed Morse stimulus with a character/gap level expected-byte model.
// Revision: 1.0
`default_nettype none

module tb_morse2ascii;

  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       morse_in = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] ascii_out;
  logic       out_valid;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  byte unsigned expq[$];
  logic exp_ovr = 1'b0;

  always #5 clk = ~clk;

  morse2ascii #(.PRESCALER(P), .MAX_ELEM(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .morse_in  (morse_in),
    .ascii_out (ascii_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hi(input int units);
    morse_in = 1'b1;
    tick(units * P);
  endtask

  task automatic lo(input int units);
    morse_in = 1'b0;
    tick(units * P);
  endtask

  function automatic string code_of(input byte unsigned c);
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  // Sends one character (ending with the line low) and records the byte it must decode to.
  task automatic send_char(input byte unsigned c);
    string s;
    s = code_of(c);
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) lo(1);
      hi((s[i] == 8'h2D) ? 3 : 1);
    end
    expq.push_back(c);
  endtask

  // Standard spacing: 3-unit char gaps, 7-unit word gaps; a low run of 6+ units yields a space.
  task automatic send_text(input string t, input int final_gap);
    for (int i = 0; i < t.len(); i++) begin
      if (t[i] == 8'h20) continue;
      if (i > 0) begin
        if (t[i-1] == 8'h20) begin
          expq.push_back(8'h20);
          lo(7);
        end else begin
          lo(3);
        end
      end
      send_char(t[i]);
    end
    if (final_gap >= 6) expq.push_back(8'h20);
    lo(final_gap);
  endtask

  // Compare process: every accepted byte against the model, and hold stability while stalled.
  initial begin
    logic       hold;
    logic [7:0] prev_a;
    hold   = 1'b0;
    prev_a = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL byte: got %02h, want no byte", ascii_out);
          end else begin
            chk("byte", {24'h0, ascii_out}, {24'h0, expq.pop_front()});
          end
          chk("overrun_at_handshake", {31'h0, overrun}, {31'h0, exp_ovr});
        end
        if (hold && out_valid) chk("hold_stable", {24'h0, ascii_out}, {24'h0, prev_a});
        hold   = out_valid && !out_ready;
        prev_a = ascii_out;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   t1, t2;
    logic pv;

    tick(3);
    chk("reset_ascii", {24'h0, ascii_out}, 32'h00);
    chk("reset_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_overrun", {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    lo(2);

    // 'E' with exact output latencies measured from the morse_in falling edge.
    hi(1);
    morse_in = 1'b0;
    expq.push_back(8'h45);
    expq.push_back(8'h20);
    t1 = -1;
    t2 = -1;
    pv = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      tick(1);
      if (out_valid && !pv) begin
        if (t1 < 0) t1 = n;
        else if (t2 < 0) t2 = n;
      end
      pv = out_valid;
    end
    chk("E_latency", t1, 15);
    chk("space_latency", t2, 47);

    send_text("SOS", 8);

    // Short glitch while idle, then a dash.
    lo(2);
    morse_in = 1'b1;
    tick(3);
    morse_in = 1'b0;
    tick(2 * P);
    send_text("T", 8);

    send_text("HI 42", 8);

    // Stalled consumer across "AB": only 'A' survives, the rest is dropped.
    out_ready = 1'b0;
    send_char("A");
    lo(3);
    hi(3); lo(1); hi(1); lo(1); hi(1); lo(1); hi(1);
    lo(8);
    chk("stall_ascii", {24'h0, ascii_out}, 32'h41);
    chk("stall_valid", {31'h0, out_valid}, 32'h1);
    chk("stall_overrun", {31'h0, overrun}, 32'h1);
    exp_ovr   = 1'b1;
    out_ready = 1'b1;
    tick(3);
    chk("drained_valid", {31'h0, out_valid}, 32'h0);
    rst = 1'b1;
    exp_ovr = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("overrun_cleared", {31'h0, overrun}, 32'h0);
    lo(2);

    // Seven dots overflow the element buffer.
    for (int i = 0; i < 7; i++) begin
      if (i > 0) lo(1);
      hi(1);
    end
    expq.push_back(8'h3F);
    expq.push_back(8'h20);
    lo(8);

    // Reset after two dots of 'S'; the partial character must vanish.
    hi(1); lo(1); hi(1);
    morse_in = 1'b0;
    tick(P / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midchar_reset_valid", {31'h0, out_valid}, 32'h0);
    lo(8);
    send_text("E", 8);

    // Line held high through reset release: that mark is ignored.
    morse_in = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2 * P);
    lo(8);
    chk("high_at_release_valid", {31'h0, out_valid}, 32'h0);
    send_text("K", 8);

    tick(10);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/morse2ascii.md
# morse2ascii

Downstream decoder for the ascii2morse serial line: samples a 1-bit on-off-keyed Morse signal in the system clock domain, measures mark/space run lengths in Morse time units, and assembles dot/dash sequences into characters. Each decoded ASCII byte is presented on a valid/ready output port. Used for loopback self-test of the encoder and as a receive path for external Morse input.

## Interface
- PRESCALER, 100000 — clk cycles per Morse time unit; must match the encoder's PRESCALER; ≥ 4.
- MAX_ELEM, 6 — maximum dots/dashes per character.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high; one clock, all state reset on `posedge clk` when `rst`=1
- morse_in  in  1  Morse line (1 = key down); asynchronous-safe
- ascii_out  out  8  decoded character; reset 0x00
- out_valid  out  1  ascii_out holds an undelivered byte; reset 0
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready
- overrun  out  1  sticky; a decoded byte was dropped; reset 0; cleared only by rst

## Operation
- **Input sync:** morse_in passes through a 2-flop synchronizer; all edges and run lengths are taken from the synchronized signal `s`.
- **Run timer:**
  - cyc_cnt is reloaded to PRESCALER/2 on every edge of `s`; each wrap of PRESCALER-1 → 0 increments units.
  - units is 3 bits, reset to 0 on each edge, saturating at 7.
  - A run of N·PRESCALER cycles therefore measures N units; runs shorter than PRESCALER/2 measure 0.
- **States:**
  - IDLE: line low, no elements pending.
  - MARK: `s`=1.
  - GAP: `s`=0, elements pending.
  - WORD: `s`=0, char emitted, space not yet emitted.
- **Mark end (falling edge), by units:**
  - 0 → glitch; the element is discarded and the state before the mark is restored.
  - 1 → dot (bit 0).
  - ≥ 2 → dash (bit 1).
  - The element is shifted into code[MAX_ELEM-1:0] LSB-first by arrival, and len increments.
  - If len is already MAX_ELEM, set the err flag instead.
- **Gap, by units while low:**
  - Rising edge with units ≤ 1 → next element of the same character (MARK).
  - units reaches 2 → end of character: emit lut(len, code), or 0x3F '?' if err or no LUT match. Clear code/len/err. Go to WORD.
  - In WORD, units reaching 6 → emit 0x20 once, then go to IDLE.
  - Rising edge in WORD before units reaches 6 → MARK; no space is emitted.
- **Emit:**
  - If out_valid=0, or out_ready=1 in the same cycle, load ascii_out and set out_valid.
  - Otherwise drop the byte and set overrun.
  - out_valid clears on handshake when nothing new is loaded.
- **Glitch in IDLE:** a high run of 0 units returns to IDLE with nothing stored.
- **Saturation:** a mark of ≥ 7 units is a dash; the unit count saturates and never wraps into a dot.

## Timing
- Sync latency: 2 cycles.
- The end-of-character byte appears with out_valid high exactly 1 cycle after the timer wrap that makes units=2 in GAP. That is 1.5·PRESCALER + 3 cycles after the morse_in falling edge.
- The space byte appears 1 cycle after units reaches 6, i.e. 5.5·PRESCALER + 3 cycles after the falling edge.
- ascii_out is stable while out_valid=1 && out_ready=0.
- Reset mid-character: the next cycle is IDLE, all counters are 0, out_valid=0, and no partial byte is emitted. A line already high at reset release is ignored until its next falling edge, which returns to IDLE (no element).

## Structure
- Package morse_pkg holds:
  - localparams UNIT_CHAR_GAP=2, UNIT_WORD_GAP=6, ASCII_SPACE=8'h20, ASCII_UNKNOWN=8'h3F;
  - the state enum.
- Sub-module morse2ascii_lut is purely combinational:
  - inputs len[2:0], code[5:0]; outputs ascii[7:0], hit.
  - covers A–Z (uppercase) and 0–9.
  - It is the inverse of ascii2morse_lut.

## Test plan
- PRESCALER=8. 'E': 1 unit high, 8 units low → one byte 0x45, then 0x20; out_valid timing per Timing.
- "SOS" with 3-unit character gaps → 0x53, 0x4F, 0x53. No 0x20 until the trailing gap reaches 6 units.
- Loopback from ascii2morse (same PRESCALER) sending "HI 42" → bytes equal the input string.
- A 3-cycle high glitch mid-gap, then a dash → the glitch is ignored and 'T' 0x54 is decoded.
- out_ready held 0 across two characters "AB" → ascii_out stays 0x41 and overrun=1. After out_ready=1: one handshake, then out_valid=0.
- 7 dots then a gap → 0x3F. rst asserted after 2 dots of 'S', then 'E' sent → only 0x45 is emitted.
